jtag_tap_driver: RTL

JTAG_TAP_DRIVER -- requirements
Module: jtag_tap_driver

---
 rtl/jtag_tap_driver_if.sv | 29 ++
 rtl/jtag_tap_driver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver_if.sv
// Command/response and JTAG pin bundle for jtag_tap_driver.
// master = command issuer + TAP model, slave = the driver.
interface jtag_tap_driver_if #(
  parameter int DW = 16
);
  localparam int LW = $clog2(DW);

  logic          START;
  logic [1:0]    CMD;
  logic [LW-1:0] LEN;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          BUSY;
  logic          DONE;
  logic          TCK;
  logic          TMS;
  logic          TDI;
  logic          TDO;

  modport master (
    output START, CMD, LEN, DIN, TDO,
    input  DOUT, BUSY, DONE, TCK, TMS, TDI
  );

  modport slave (
    input  START, CMD, LEN, DIN, TDO,
    output DOUT, BUSY, DONE, TCK, TMS, TDI
  );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG TAP sequencer: TAP reset, IR/DR scans and Run-Test-Idle
// cycles, TCK = CLK/2, target TAP always left in Run-Test-Idle.
module jtag_tap_driver #(
  parameter int DW = 16
) (
  input logic              CLK,
  input logic              RST_N,
  jtag_tap_driver_if.slave bus
);
  localparam int LW = $clog2(DW);
  localparam int CW = (LW > 3) ? LW : 3;

  typedef enum logic [2:0] {
    RST_SEQ, IDLE, HDR, SHIFT, TRAIL, RUN
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_tck, w_tck;
  logic          r_tms, w_tms;
  logic          r_tdi, w_tdi;
  logic          r_ir, w_ir;
  logic          r_scan, w_scan;
  logic          r_auto, w_auto;
  logic          r_fin, w_fin;
  logic          r_done, w_done;
  logic [LW-1:0] r_len, w_len;
  logic [DW-1:0] r_din, w_din;
  logic [DW-1:0] r_cap, w_cap;
  logic [DW-1:0] r_dout, w_dout;
  logic [CW-1:0] w_lenc;

  assign w_lenc = CW'(r_len);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RST_SEQ;
      r_cnt   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_ir    <= 1'b0;
      r_scan  <= 1'b0;
      r_auto  <= 1'b1;
      r_fin   <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_din   <= '0;
      r_cap   <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_tck   <= w_tck;
      r_tms   <= w_tms;
      r_tdi   <= w_tdi;
      r_ir    <= w_ir;
      r_scan  <= w_scan;
      r_auto  <= w_auto;
      r_fin   <= w_fin;
      r_done  <= w_done;
      r_len   <= w_len;
      r_din   <= w_din;
      r_cap   <= w_cap;
      r_dout  <= w_dout;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_tck   = r_tck;
    w_tms   = r_tms;
    w_tdi   = r_tdi;
    w_ir    = r_ir;
    w_scan  = r_scan;
    w_auto  = r_auto;
    w_fin   = r_fin;
    w_done  = 1'b0;
    w_len   = r_len;
    w_din   = r_din;
    w_cap   = r_cap;
    w_dout  = r_dout;
    if (r_state == IDLE) begin
      if (bus.START) begin
        w_len  = bus.LEN;
        w_din  = bus.DIN;
        w_cap  = '0;
        w_cnt  = '0;
        w_tdi  = 1'b0;
        w_fin  = 1'b0;
        w_auto = 1'b0;
        w_ir   = (bus.CMD == 2'b01);
        w_scan = bus.CMD[1] ^ bus.CMD[0];
        unique case (bus.CMD)
          2'b00: begin
            w_state = RST_SEQ;
            w_tms   = 1'b1;
          end
          2'b01, 2'b10: begin
            w_state = HDR;
            w_tms   = 1'b1;
          end
          default: begin
            w_state = RUN;
            w_tms   = 1'b0;
          end
        endcase
      end
    end else if (r_fin) begin
      // one settle cycle after the last TCK fall
      w_state = IDLE;
      w_fin   = 1'b0;
      w_auto  = 1'b0;
      w_done  = !r_auto;
      if (r_scan && !r_auto)
        w_dout = r_cap;
    end else if (!r_tck) begin
      w_tck = 1'b1;
      if (r_state == SHIFT)
        w_cap[r_cnt[LW-1:0]] = bus.TDO;
    end else begin
      // TCK falling: advance and set up the next period
      w_tck = 1'b0;
      w_cnt = r_cnt + CW'(1);
      case (r_state)
        RST_SEQ: begin
          if (r_cnt == CW'(5))
            w_fin = 1'b1;
          else
            w_tms = (w_cnt < CW'(5));
        end
        HDR: begin
          if (r_cnt == (r_ir ? CW'(3) : CW'(2))) begin
            w_state = SHIFT;
            w_cnt   = '0;
            w_tms   = (r_len == '0);
            w_tdi   = r_din[0];
            w_din   = {1'b0, r_din[DW-1:1]};
          end else begin
            w_tms = r_ir && (w_cnt == CW'(1));
          end
        end
        SHIFT: begin
          if (r_cnt == w_lenc) begin
            w_state = TRAIL;
            w_cnt   = '0;
            w_tms   = 1'b1;
            w_tdi   = 1'b0;
          end else begin
            w_tms = (w_cnt == w_lenc);
            w_tdi = r_din[0];
            w_din = {1'b0, r_din[DW-1:1]};
          end
        end
        TRAIL: begin
          if (r_cnt == CW'(1))
            w_fin = 1'b1;
          else
            w_tms = 1'b0;
        end
        RUN: begin
          if (r_cnt == w_lenc)
            w_fin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.DOUT = r_dout;
  assign bus.BUSY = (r_state != IDLE);
  assign bus.DONE = r_done;
  assign bus.TCK  = r_tck;
  assign bus.TMS  = r_tms;
  assign bus.TDI  = r_tdi;
endmodule
